// File: rtl/ldpc_encoder.sv
// Systematic (12,6) LDPC encoder with a bit-serial parity accumulator and BPSK LLR mapping.
// Latency 7 cycles from acceptance to done; msg_ready low while encoding, msg_valid ignored then.
module ldpc_encoder #(
  parameter logic [5:0] LLR_MAG = 6'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        msg_valid,
  input  logic [5:0]  msg,
  output logic        msg_ready,
  output logic [11:0] codeword,
  output logic [71:0] lambda,
  output logic        lambda_valid,
  output logic        done
);

  typedef enum logic {
    IDLE = 1'b0,
    ENC  = 1'b1
  } state_t;

  // Clamp keeps the negative mapping away from -32 even with an out-of-range override.
  localparam logic [5:0] MAG     = (LLR_MAG == 6'd0) ? 6'd1 :
                                   (LLR_MAG > 6'd31) ? 6'd31 : LLR_MAG;
  localparam logic [5:0] MAG_NEG = ~MAG + 6'd1;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  msg_q;
  logic [5:0]  acc;
  logic [5:0]  acc_nxt;
  logic [2:0]  cnt;
  logic        last_bit;
  logic        done_q;
  logic [11:0] cw_nxt;
  logic [71:0] lambda_nxt;

  function automatic logic [5:0] parity_row(input logic [2:0] idx);
    logic [5:0] row;
    case (idx)
      3'd0:    row = 6'b000111;
      3'd1:    row = 6'b001011;
      3'd2:    row = 6'b010101;
      3'd3:    row = 6'b100110;
      3'd4:    row = 6'b011001;
      3'd5:    row = 6'b111000;
      default: row = 6'b000000;
    endcase
    return row;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (msg_valid) state_nxt = ENC;
      ENC:     if (cnt == 3'd5) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    msg_ready = (state == IDLE);
    last_bit  = (state == ENC) && (cnt == 3'd5);
  end

  // One message bit per ENC cycle folds its parity row into the accumulator.
  always_comb begin
    acc_nxt = acc;
    if (msg_q[cnt]) begin
      acc_nxt = acc ^ parity_row(cnt);
    end
    cw_nxt = {acc_nxt, msg_q};
  end

  always_comb begin
    lambda_nxt = '0;
    for (int j = 0; j < 12; j++) begin
      lambda_nxt[6*j +: 6] = cw_nxt[j] ? MAG_NEG : MAG;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msg_q    <= '0;
      acc      <= '0;
      cnt      <= '0;
      codeword <= '0;
      lambda   <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (msg_valid) begin
          msg_q <= msg;
          acc   <= '0;
          cnt   <= '0;
        end
      end else begin
        acc <= acc_nxt;
        cnt <= cnt + 3'd1;
        // Results only move on the final bit, so they stay stable between done pulses.
        if (last_bit) begin
          codeword <= cw_nxt;
          lambda   <= lambda_nxt;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign done         = done_q;
  assign lambda_valid = done_q;

endmodule

// File: tb/tb_ldpc_encoder.sv
// Randomized and directed bench for ldpc_encoder against a queue-based scoreboard.
module tb_ldpc_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        msg_valid;
  logic [5:0]  msg;
  logic        msg_ready;
  logic [11:0] codeword;
  logic [71:0] lambda;
  logic        lambda_valid;
  logic        done;

  int n_tot = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_acc = 0;
  int n_done = 0;
  bit armed = 1'b0;

  logic [5:0]  exp_msg[$];
  int          exp_cyc[$];
  logic [11:0] last_cw;
  logic [71:0] last_lam;
  logic [5:0]  mon_m;
  int          mon_c;
  logic [11:0] mon_cw;

  ldpc_encoder #(.LLR_MAG(6'd15)) dut (
    .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg(msg),
    .msg_ready(msg_ready), .codeword(codeword), .lambda(lambda),
    .lambda_valid(lambda_valid), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: parity is the GF(2) sum of the generator rows selected by the message bits.
  function automatic logic [11:0] ref_cw(input logic [5:0] m);
    logic [5:0] rows [6];
    logic [5:0] p;
    rows = '{6'b000111, 6'b001011, 6'b010101, 6'b100110, 6'b011001, 6'b111000};
    p = '0;
    for (int i = 0; i < 6; i++) if (m[i]) p = p ^ rows[i];
    return {p, m};
  endfunction

  function automatic logic [71:0] ref_lam(input logic [11:0] cw);
    logic [71:0] l;
    int v;
    l = '0;
    for (int j = 0; j < 12; j++) begin
      v = cw[j] ? -15 : 15;
      l[6*j +: 6] = v[5:0];
    end
    return l;
  endfunction

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_msg.delete();
      exp_cyc.delete();
      last_cw  = '0;
      last_lam = '0;
      armed    = 1'b1;
    end else if (armed) begin
      if (done) begin
        if (exp_msg.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          mon_m  = exp_msg.pop_front();
          mon_c  = exp_cyc.pop_front();
          mon_cw = ref_cw(mon_m);
          chk("codeword", codeword, mon_cw);
          chk("lambda", lambda, ref_lam(mon_cw));
          chk("latency", cyc - mon_c, 7);
          last_cw  = mon_cw;
          last_lam = ref_lam(mon_cw);
          n_done++;
        end
        chk("lambda_valid_hi", lambda_valid, 1);
      end else begin
        chk("hold_cw", codeword, last_cw);
        chk("hold_lambda", lambda, last_lam);
        chk("lambda_valid_lo", lambda_valid, 0);
      end
      chk("msg_ready", msg_ready, exp_msg.size() == 0);
      if (msg_valid && exp_msg.size() == 0) begin
        exp_msg.push_back(msg);
        exp_cyc.push_back(cyc);
        n_acc++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_msg.size() != 0; k++) step();
    chk("drain_timeout", exp_msg.size() == 0, 1);
  endtask

  task automatic send(input logic [5:0] m);
    drain();
    msg = m;
    msg_valid = 1'b1;
    step();
    msg_valid = 1'b0;
    drain();
  endtask

  task automatic send_noisy(input logic [5:0] m);
    drain();
    msg = m;
    msg_valid = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      msg = 6'($urandom);
      msg_valid = 1'($urandom);
      step();
    end
    msg_valid = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int d0;
    rst = 1'b1;
    msg_valid = 1'b1;
    msg = 6'h3F;
    step();
    step();
    chk("rst_codeword", codeword, 12'h000);
    chk("rst_lambda", lambda, 72'h0);
    chk("rst_done", done, 0);
    chk("rst_lambda_valid", lambda_valid, 0);
    msg_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("ready_after_rst", msg_ready, 1);

    // Directed vectors with hand-derived constants.
    send(6'b000001);
    chk("dir_cw_1c1", codeword, 12'h1C1);
    chk("dir_lam_1c1", lambda, {{3{6'b001111}}, {3{6'b110001}}, {5{6'b001111}}, 6'b110001});
    send(6'b000011);
    chk("dir_cw_303", codeword, 12'h303);
    send(6'b111111);
    chk("dir_cw_7bf", codeword, 12'h7BF);
    send(6'b000000);
    chk("dir_cw_000", codeword, 12'h000);
    chk("dir_lam_000", lambda, {12{6'b001111}});

    // Gapless back-to-back with msg_valid held high.
    drain();
    a0 = n_acc;
    msg_valid = 1'b1;
    for (int k = 0; k < 42; k++) begin
      msg = ((n_acc - a0) % 2 == 1) ? 6'd63 : 6'd1;
      step();
    end
    msg_valid = 1'b0;
    chk("gapless_accepts", n_acc - a0, 6);
    drain();

    // Input noise during encoding must not disturb the captured message.
    for (int k = 0; k < 4; k++) send_noisy(6'($urandom));

    // Reset sampled on the 3rd ENC edge aborts the encode.
    drain();
    d0 = n_done;
    msg = 6'h2A;
    msg_valid = 1'b1;
    step();
    msg_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    chk("abort_codeword", codeword, 12'h000);
    chk("abort_lambda", lambda, 72'h0);
    chk("abort_done", done, 0);
    rst = 1'b0;
    step();
    chk("ready_post_abort", msg_ready, 1);
    for (int k = 0; k < 8; k++) step();
    chk("abort_no_done", n_done - d0, 0);
    send(6'h15);
    chk("post_abort_cw", codeword, ref_cw(6'h15));

    // Random traffic with random idle gaps.
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) step();
      send_noisy(6'($urandom));
    end

    // Every message value once.
    for (int i = 0; i < 64; i++) send(6'(i));

    step();
    step();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/ldpc_encoder.md
LDPC_ENCODER -- requirements
Module: ldpc_encoder

Interface
REQ-001 Parameter LLR_MAG, default 6'd15: unsigned magnitude of the channel LLR emitted per code bit; legal range 1..31.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 msg_valid  input  1  message present on msg this cycle.
REQ-005 msg  input  6  information bits m[5:0].
REQ-006 msg_ready  output  1  encoder idle and able to accept a message.
REQ-007 codeword  output  12  systematic codeword: bits [5:0] = m[5:0], bits [11:6] = parity p[5:0].
REQ-008 lambda  output  72  BPSK-mapped LLRs; code bit j occupies lambda[6*j+5:6*j], two's complement; directly drives the decoder lambda port.
REQ-009 lambda_valid  output  1  one-cycle pulse; lambda valid, decoder may sample.
REQ-010 done  output  1  one-cycle pulse coincident with lambda_valid; codeword valid.

Function
REQ-011 The parity rows SHALL be fixed constants: ROW0=000111, ROW1=001011, ROW2=010101, ROW3=100110, ROW4=011001, ROW5=111000.
REQ-012 The encoder SHALL compute p = XOR of ROWi over every i with m[i]=1, in mod-2 arithmetic.
REQ-013 The FSM SHALL have two states: IDLE and ENC.
REQ-014 In IDLE, msg_ready SHALL be 1; in ENC, msg_ready SHALL be 0.
REQ-015 In IDLE, a rising edge with msg_valid=1 SHALL capture msg into an internal register, clear the parity accumulator and bit counter, and enter ENC.
REQ-016 In ENC, each edge SHALL process one message bit, i = counter value 0..5 ascending, XORing ROWi into the accumulator when m[i]=1, then incrementing the counter.
REQ-017 On the edge processing bit 5, the block SHALL register codeword and lambda from the final parity, assert done and lambda_valid for the next cycle only, and return to IDLE.
REQ-018 Latency: for acceptance at edge T, done=lambda_valid=1 during the cycle after edge T+6; throughput is one message per 7 cycles.
REQ-019 A message SHALL be acceptable in the same cycle that done is high, so back-to-back operation is gapless at 7 cycles per message.
REQ-020 The block SHALL ignore msg_valid while in ENC, leaving the in-flight computation undisturbed.
REQ-021 The block SHALL hold codeword and lambda stable from the done pulse until the next done pulse.
REQ-022 LLR mapping SHALL be: code bit 0 -> +LLR_MAG; code bit 1 -> -LLR_MAG as 6-bit two's complement (default: 001111 / 110001).
REQ-023 Value -32 SHALL never be produced.
REQ-024 msg changing after the capture edge SHALL NOT affect the result.

Reset
REQ-025 While rst=1 at an edge, the block SHALL enter IDLE and clear the counter, accumulator and captured message.
REQ-026 While rst=1 at an edge, the block SHALL drive codeword=0, lambda=0, done=0 and lambda_valid=0.
REQ-027 Reset SHALL take priority over msg_valid.
REQ-028 Reset asserted mid-ENC SHALL abort the encode, with no done pulse for the aborted message.
REQ-029 msg_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-030 Scenario: reset, msg=000001 with msg_valid 1 cycle -> after 7 edges codeword=12'h1C1 and done=1 for exactly 1 cycle; lambda bit0=110001, bits1..5=001111, bits6..8=110001, bits9..11=001111.
REQ-031 Scenario: msg=000011 -> codeword=12'h303; msg=111111 -> codeword=12'h7BF; msg=000000 -> codeword=12'h000 with all lambda fields=001111.
REQ-032 Scenario: msg_valid held high with msg alternating 000001 and 111111 -> done every 7 cycles with codewords 1C1, 7BF, 1C1, ...; msg_ready low for 6 cycles of each message.
REQ-033 Scenario: msg changed and msg_valid pulsed during ENC -> result still matches the originally captured message, with no extra done pulse.
REQ-034 Scenario: rst asserted on the 3rd ENC edge -> no done pulse, outputs zero, msg_ready=1 the cycle after rst drops, and the next message encodes correctly.
REQ-035 Scenario: loopback of lambda/lambda_valid into ldpc_decoder for all 64 messages -> decoder v_hat equals codeword for each message.
